writeback_unit: RTL and testbench

Final pipeline stage that retires results into the register file. It accepts completed results over a valid/ready handshake and buffers them in a small in-order FIFO. It drains one entry per cycle onto the register-file write port (`write_port_address`, `write_data`, `is_write`), which the operand-fetch stage currently ties off. It also keeps a per-register pending-write scoreboard so operand fetch can stall on read-after-write hazards.

---
 rtl/writeback_unit.sv | 125 ++++++++++++
 tb/tb_writeback_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Retirement stage: buffers completed results in an in-order FIFO, drains one per cycle
// onto the register-file write port, and tracks pending writes per register for hazard stalls.
module writeback_unit #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     issue_stall,
    output logic [(1<<ADDR_W)-1:0]   busy,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [ADDR_W-1:0]        res_addr,
    input  logic [DATA_W-1:0]        res_data,
    input  logic                     wr_hold,
    output logic                     is_write,
    output logic [ADDR_W-1:0]        write_port_address,
    output logic [DATA_W-1:0]        write_data
);
    localparam int NREG  = 1 << ADDR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              res_ready_reg;

    logic              out_valid_reg;
    logic [ADDR_W-1:0] out_addr_reg;
    logic [DATA_W-1:0] out_data_reg;

    logic [CNT_W-1:0]  outstanding_reg;
    logic [CNT_W-1:0]  outstanding_next;
    logic [NREG-1:0]   busy_reg;
    logic [NREG-1:0]   busy_next;

    logic push;
    logic pop;
    logic commit;
    logic issue_accept;
    logic retire_tracked;

    assign push         = res_valid & res_ready_reg;
    assign commit       = out_valid_reg & ~wr_hold;
    // The output register refills from the head whenever it is free or being freed this edge.
    assign pop          = (~out_valid_reg | commit) & (count_reg != '0);
    assign issue_stall  = busy_reg[issue_addr] | (outstanding_reg == DEPTH_CNT);
    assign issue_accept = issue_valid & ~issue_stall;

    // A write to a register with no pending issue is still performed but does not retire an issue.
    assign retire_tracked = commit & busy_reg[out_addr_reg];

    assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    assign outstanding_next = outstanding_reg + CNT_W'(issue_accept) - CNT_W'(retire_tracked);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            assign busy_next[gi] =
                (busy_reg[gi] & ~(commit && (out_addr_reg == ADDR_W'(gi))))
                | (issue_accept && (issue_addr == ADDR_W'(gi)));
        end
    endgenerate

    // Storage array carries no reset so it maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= res_data;
            addr_mem[wr_ptr_reg] <= res_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            res_ready_reg <= 1'b1;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg     <= count_next;
            res_ready_reg <= (count_next != DEPTH_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_addr_reg  <= '0;
            out_data_reg  <= '0;
        end else if (pop) begin
            out_valid_reg <= 1'b1;
            out_addr_reg  <= addr_mem[rd_ptr_reg];
            out_data_reg  <= data_mem[rd_ptr_reg];
        end else if (commit) begin
            out_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg        <= '0;
            outstanding_reg <= '0;
        end else begin
            busy_reg        <= busy_next;
            outstanding_reg <= outstanding_next;
        end
    end

    assign busy               = busy_reg;
    assign res_ready          = res_ready_reg;
    assign is_write           = out_valid_reg;
    assign write_port_address = out_addr_reg;
    assign write_data         = out_data_reg;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: latency, throughput, backpressure, hazard stalls and reset.
module tb_writeback_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [3:0]  issue_addr = '0;
    logic        issue_stall;
    logic [15:0] busy;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [3:0]  res_addr = '0;
    logic [63:0] res_data = '0;
    logic        wr_hold = 1'b0;
    logic        is_write;
    logic [3:0]  write_port_address;
    logic [63:0] write_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    writeback_unit #(.DATA_W(64), .ADDR_W(4), .DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .issue_valid(issue_valid),
        .issue_addr(issue_addr),
        .issue_stall(issue_stall),
        .busy(busy),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_addr(res_addr),
        .res_data(res_data),
        .wr_hold(wr_hold),
        .is_write(is_write),
        .write_port_address(write_port_address),
        .write_data(write_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && is_write && !wr_hold)
            $display("commit r%0d <= %h", write_port_address, write_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (is_write !== 1'b0) $display("FAIL reset_is_write got %b want 0", is_write); else pass_cnt++;
        total_cnt++;
        if (busy !== 16'h0000) $display("FAIL reset_busy got %h want 0000", busy); else pass_cnt++;
        total_cnt++;
        if (res_ready !== 1'b1) $display("FAIL reset_res_ready got %b want 1", res_ready); else pass_cnt++;
        total_cnt++;
        if (write_port_address !== 4'd0 || write_data !== 64'd0)
            $display("FAIL reset_port got %0d/%h want 0/0", write_port_address, write_data);
        else pass_cnt++;
        reset = 1'b0;
        issue_addr = 4'd0;
        #1;
        total_cnt++;
        if (issue_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", issue_stall); else pass_cnt++;
    endtask

    task automatic test_single();
        issue_valid = 1'b1;
        issue_addr = 4'd3;
        tick();
        issue_valid = 1'b0;
        total_cnt++;
        if (busy !== 16'h0008) $display("FAIL single_busy_set got %h want 0008", busy); else pass_cnt++;
        res_valid = 1'b1;
        res_addr = 4'd3;
        res_data = 64'hDEAD_BEEF;
        tick();
        res_valid = 1'b0;
        total_cnt++;
        if (is_write !== 1'b0) $display("FAIL single_early_write got %b want 0", is_write); else pass_cnt++;
        tick();
        total_cnt++;
        if (is_write !== 1'b1 || write_port_address !== 4'd3 || write_data !== 64'hDEAD_BEEF)
            $display("FAIL single_write got %b r%0d %h want 1 r3 00000000deadbeef",
                     is_write, write_port_address, write_data);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 16'h0008) $display("FAIL single_busy_before_commit got %h want 0008", busy); else pass_cnt++;
        tick();
        total_cnt++;
        if (is_write !== 1'b0) $display("FAIL single_pulse_len got %b want 0", is_write); else pass_cnt++;
        total_cnt++;
        if (busy !== 16'h0000) $display("FAIL single_busy_clear got %h want 0000", busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            issue_valid = 1'b1;
            issue_addr = 4'(i);
            tick();
        end
        issue_valid = 1'b0;
        total_cnt++;
        if (busy !== 16'h001E) $display("FAIL b2b_busy got %h want 001e", busy); else pass_cnt++;
        for (int k = 0; k < 6; k++) begin
            res_valid = (k < 4);
            res_addr = 4'(k + 1);
            res_data = 64'(k + 1);
            if (k < 4) begin
                total_cnt++;
                if (res_ready !== 1'b1) $display("FAIL b2b_ready cycle %0d got %b want 1", k, res_ready); else pass_cnt++;
            end
            tick();
            if (k >= 1 && k <= 4) begin
                total_cnt++;
                if (is_write !== 1'b1 || write_port_address !== 4'(k) || write_data !== 64'(k))
                    $display("FAIL b2b_commit cycle %0d got %b r%0d %h want 1 r%0d %0d",
                             k, is_write, write_port_address, write_data, k, k);
                else pass_cnt++;
            end
        end
        res_valid = 1'b0;
        total_cnt++;
        if (is_write !== 1'b0) $display("FAIL b2b_idle got %b want 0", is_write); else pass_cnt++;
        total_cnt++;
        if (busy !== 16'h0000) $display("FAIL b2b_busy_clear got %h want 0000", busy); else pass_cnt++;
    endtask

    task automatic test_hold();
        int idx = 0;
        int commits = 0;
        bit will_push;
        wr_hold = 1'b1;
        for (int c = 0; c < 8; c++) begin
            res_valid = (idx < 6);
            res_addr = 4'(8 + idx);
            res_data = 64'(100 + idx);
            will_push = res_valid && res_ready;
            tick();
            if (will_push) idx++;
            if (c >= 1) begin
                total_cnt++;
                if (is_write !== 1'b1 || write_port_address !== 4'd8 || write_data !== 64'd100)
                    $display("FAIL hold_stable cycle %0d got %b r%0d %0d want 1 r8 100",
                             c, is_write, write_port_address, write_data);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (idx !== 5) $display("FAIL hold_accepted got %0d want 5", idx); else pass_cnt++;
        total_cnt++;
        if (res_ready !== 1'b0) $display("FAIL hold_ready got %b want 0", res_ready); else pass_cnt++;
        wr_hold = 1'b0;
        for (int c = 0; c < 20 && commits < 6; c++) begin
            res_valid = (idx < 6);
            res_addr = 4'(8 + idx);
            res_data = 64'(100 + idx);
            if (is_write) begin
                total_cnt++;
                if (write_port_address !== 4'(8 + commits) || write_data !== 64'(100 + commits))
                    $display("FAIL hold_order commit %0d got r%0d %0d want r%0d %0d",
                             commits, write_port_address, write_data, 8 + commits, 100 + commits);
                else pass_cnt++;
                commits++;
            end
            will_push = res_valid && res_ready;
            tick();
            if (will_push) idx++;
        end
        res_valid = 1'b0;
        total_cnt++;
        if (commits !== 6) $display("FAIL hold_commit_count got %0d want 6", commits); else pass_cnt++;
        total_cnt++;
        if (is_write !== 1'b0) $display("FAIL hold_drained got %b want 0", is_write); else pass_cnt++;
        total_cnt++;
        if (busy !== 16'h0000) $display("FAIL hold_untracked_busy got %h want 0000", busy); else pass_cnt++;
    endtask

    task automatic test_stall();
        issue_valid = 1'b1;
        issue_addr = 4'd5;
        tick();
        total_cnt++;
        if (busy !== 16'h0020) $display("FAIL stall_busy5 got %h want 0020", busy); else pass_cnt++;
        #1;
        total_cnt++;
        if (issue_stall !== 1'b1) $display("FAIL stall_raw got %b want 1", issue_stall); else pass_cnt++;
        tick();
        issue_valid = 1'b0;
        res_valid = 1'b1;
        res_addr = 4'd5;
        res_data = 64'h55;
        tick();
        res_valid = 1'b0;
        tick();
        total_cnt++;
        if (is_write !== 1'b1 || write_port_address !== 4'd5)
            $display("FAIL stall_commit_cycle got %b r%0d want 1 r5", is_write, write_port_address);
        else pass_cnt++;
        issue_valid = 1'b1;
        issue_addr = 4'd5;
        #1;
        total_cnt++;
        if (issue_stall !== 1'b1) $display("FAIL stall_same_at_commit got %b want 1", issue_stall); else pass_cnt++;
        issue_addr = 4'd6;
        #1;
        total_cnt++;
        if (issue_stall !== 1'b0) $display("FAIL stall_other_at_commit got %b want 0", issue_stall); else pass_cnt++;
        tick();
        issue_valid = 1'b0;
        total_cnt++;
        if (busy !== 16'h0040) $display("FAIL stall_swap_busy got %h want 0040", busy); else pass_cnt++;
    endtask

    task automatic test_full();
        // r6 is already outstanding; three more fill the tracker.
        for (int i = 7; i <= 9; i++) begin
            issue_valid = 1'b1;
            issue_addr = 4'(i);
            tick();
        end
        issue_valid = 1'b0;
        total_cnt++;
        if (busy !== 16'h03C0) $display("FAIL full_busy got %h want 03c0", busy); else pass_cnt++;
        issue_addr = 4'd10;
        #1;
        total_cnt++;
        if (issue_stall !== 1'b1) $display("FAIL full_stall got %b want 1", issue_stall); else pass_cnt++;
        res_valid = 1'b1;
        res_addr = 4'd6;
        res_data = 64'h66;
        tick();
        res_valid = 1'b0;
        tick();
        total_cnt++;
        if (issue_stall !== 1'b1) $display("FAIL full_stall_precommit got %b want 1", issue_stall); else pass_cnt++;
        tick();
        total_cnt++;
        if (issue_stall !== 1'b0) $display("FAIL full_stall_drop got %b want 0", issue_stall); else pass_cnt++;
        for (int i = 7; i <= 9; i++) begin
            res_valid = 1'b1;
            res_addr = 4'(i);
            res_data = 64'(i);
            tick();
        end
        res_valid = 1'b0;
        tick();
        tick();
        tick();
        total_cnt++;
        if (busy !== 16'h0000) $display("FAIL full_drain_busy got %h want 0000", busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 2; i++) begin
            issue_valid = 1'b1;
            issue_addr = 4'(i);
            tick();
        end
        issue_valid = 1'b0;
        wr_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            res_valid = 1'b1;
            res_addr = 4'(i);
            res_data = 64'(16'hA0 + i);
            tick();
        end
        res_valid = 1'b0;
        total_cnt++;
        if (is_write !== 1'b1 || write_port_address !== 4'd1)
            $display("FAIL rstmid_pending got %b r%0d want 1 r1", is_write, write_port_address);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if (is_write !== 1'b0) $display("FAIL rstmid_is_write got %b want 0", is_write); else pass_cnt++;
        total_cnt++;
        if (busy !== 16'h0000) $display("FAIL rstmid_busy got %h want 0000", busy); else pass_cnt++;
        total_cnt++;
        if (res_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", res_ready); else pass_cnt++;
        issue_addr = 4'd1;
        #1;
        total_cnt++;
        if (issue_stall !== 1'b0) $display("FAIL rstmid_stall got %b want 0", issue_stall); else pass_cnt++;
        wr_hold = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            total_cnt++;
            if (is_write !== 1'b0)
                $display("FAIL rstmid_stale cycle %0d got %b r%0d want 0", c, is_write, write_port_address);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_stall();
        test_full();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
